// File: rtl/alu_op_sequencer.sv
// Issue/retire sequencer between the decoder and a combinational 32-bit ALU.
// Optional perf counters (perf_issued, perf_taken, perf_clr) with SEQ_PERF_CNT_EN.
module alu_op_sequencer #(
  parameter int          SETTLE_CYCLES = 2,
  parameter int unsigned PC_W          = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [3:0]      cmd_op,
  input  logic [31:0]     cmd_a,
  input  logic [31:0]     cmd_b,
  input  logic [PC_W-1:0] cmd_pc,
  input  logic [PC_W-1:0] cmd_off,
  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  output logic [2:0]      alu_op,
  output logic            alu_b_inv,
  output logic            alu_cin,
  output logic [1:0]      alu_br_type,
  input  logic [31:0]     alu_result,
  input  logic            alu_cout,
  input  logic            alu_will_branch,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_data,
  output logic            rsp_wb,
  output logic            rsp_br_taken,
  output logic [PC_W-1:0] rsp_br_target,
  output logic            rsp_err,
`ifdef SEQ_PERF_CNT_EN
  input  logic            perf_clr,
  output logic [31:0]     perf_issued,
  output logic [31:0]     perf_taken,
`endif
  output logic            carry_flag
);

  localparam int unsigned CNT_W = 4;

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..15");
  end

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, RESP} state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [3:0]        op_q, op_d;
  logic [PC_W-1:0]   pc_q, pc_d, off_q, off_d;
  logic              cmd_ready_d;
  logic [31:0]       alu_a_d, alu_b_d;
  logic [2:0]        alu_op_d;
  logic              alu_b_inv_d, alu_cin_d;
  logic [1:0]        alu_br_type_d;
  logic              rsp_valid_d, rsp_wb_d, rsp_br_taken_d, rsp_err_d;
  logic [31:0]       rsp_data_d;
  logic [PC_W-1:0]   rsp_br_target_d;
  logic              carry_flag_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      op_q          <= '0;
      pc_q          <= '0;
      off_q         <= '0;
      cmd_ready     <= 1'b0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_op        <= '0;
      alu_b_inv     <= 1'b0;
      alu_cin       <= 1'b0;
      alu_br_type   <= 2'b11;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_wb        <= 1'b0;
      rsp_br_taken  <= 1'b0;
      rsp_br_target <= '0;
      rsp_err       <= 1'b0;
      carry_flag    <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      op_q          <= op_d;
      pc_q          <= pc_d;
      off_q         <= off_d;
      cmd_ready     <= cmd_ready_d;
      alu_a         <= alu_a_d;
      alu_b         <= alu_b_d;
      alu_op        <= alu_op_d;
      alu_b_inv     <= alu_b_inv_d;
      alu_cin       <= alu_cin_d;
      alu_br_type   <= alu_br_type_d;
      rsp_valid     <= rsp_valid_d;
      rsp_data      <= rsp_data_d;
      rsp_wb        <= rsp_wb_d;
      rsp_br_taken  <= rsp_br_taken_d;
      rsp_br_target <= rsp_br_target_d;
      rsp_err       <= rsp_err_d;
      carry_flag    <= carry_flag_d;
    end
  end

  always_comb begin
    state_d         = state;
    cnt_d           = cnt;
    op_d            = op_q;
    pc_d            = pc_q;
    off_d           = off_q;
    alu_a_d         = alu_a;
    alu_b_d         = alu_b;
    alu_op_d        = alu_op;
    alu_b_inv_d     = alu_b_inv;
    alu_cin_d       = alu_cin;
    alu_br_type_d   = alu_br_type;
    rsp_valid_d     = rsp_valid;
    rsp_data_d      = rsp_data;
    rsp_wb_d        = rsp_wb;
    rsp_br_taken_d  = rsp_br_taken;
    rsp_br_target_d = rsp_br_target;
    rsp_err_d       = rsp_err;
    carry_flag_d    = carry_flag;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d  = cmd_op;
          pc_d  = cmd_pc;
          off_d = cmd_off;
          if (cmd_op >= 4'd12) begin
            // Illegal command bypasses the ALU entirely
            state_d         = RESP;
            rsp_valid_d     = 1'b1;
            rsp_err_d       = 1'b1;
            rsp_data_d      = '0;
            rsp_wb_d        = 1'b0;
            rsp_br_taken_d  = 1'b0;
            rsp_br_target_d = '0;
          end else begin
            state_d       = SETTLE;
            cnt_d         = CNT_W'(SETTLE_CYCLES - 1);
            alu_a_d       = cmd_a;
            alu_b_d       = cmd_b;
            alu_op_d      = 3'b010;
            alu_b_inv_d   = 1'b0;
            alu_cin_d     = 1'b0;
            alu_br_type_d = 2'b11;
            case (cmd_op)
              4'd1:    begin alu_b_inv_d = 1'b1; alu_cin_d = 1'b1; end
              4'd2:    alu_op_d = 3'b000;
              4'd3:    alu_op_d = 3'b001;
              4'd4:    alu_op_d = 3'b101;
              4'd5:    alu_op_d = 3'b110;
              4'd6:    alu_op_d = 3'b111;
              4'd7:    begin alu_a_d = '0; alu_b_inv_d = 1'b1; alu_cin_d = 1'b1; end
              4'd8:    alu_cin_d = carry_flag;
              4'd9:    begin alu_b_d = '0; alu_br_type_d = 2'b00; end
              4'd10:   begin alu_b_d = '0; alu_br_type_d = 2'b01; end
              4'd11:   begin alu_b_d = '0; alu_br_type_d = 2'b10; end
              default: ;
            endcase
          end
        end
      end
      SETTLE: begin
        if (cnt == '0) state_d = CAPTURE;
        else           cnt_d   = cnt - 1'b1;
      end
      CAPTURE: begin
        state_d         = RESP;
        rsp_valid_d     = 1'b1;
        rsp_err_d       = 1'b0;
        rsp_data_d      = alu_result;
        rsp_wb_d        = (op_q <= 4'd8);
        rsp_br_taken_d  = (op_q >= 4'd9) && alu_will_branch;
        rsp_br_target_d = pc_q + off_q;
        if (op_q inside {4'd0, 4'd1, 4'd7, 4'd8}) carry_flag_d = alu_cout;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b0;
          alu_br_type_d = 2'b11;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

`ifdef SEQ_PERF_CNT_EN
  // Counters: clear wins over increment, wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued <= '0;
      perf_taken  <= '0;
    end else if (perf_clr) begin
      perf_issued <= '0;
      perf_taken  <= '0;
    end else begin
      if (cmd_valid && cmd_ready)                  perf_issued <= perf_issued + 32'd1;
      if (rsp_valid && rsp_ready && rsp_br_taken)  perf_taken  <= perf_taken + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer with a behavioural ALU.
// Covers perf counters when SEQ_PERF_CNT_EN is defined.
module tb_alu_op_sequencer;
  localparam int          SETTLE = 2;
  localparam int unsigned PC_W   = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_valid, cmd_ready;
  logic [3:0]      cmd_op;
  logic [31:0]     cmd_a, cmd_b;
  logic [PC_W-1:0] cmd_pc, cmd_off;
  logic [31:0]     alu_a, alu_b, alu_result;
  logic [2:0]      alu_op;
  logic            alu_b_inv, alu_cin, alu_cout, alu_will_branch;
  logic [1:0]      alu_br_type;
  logic            rsp_valid, rsp_ready, rsp_wb, rsp_br_taken, rsp_err;
  logic [31:0]     rsp_data;
  logic [PC_W-1:0] rsp_br_target;
  logic            carry_flag;
`ifdef SEQ_PERF_CNT_EN
  logic            perf_clr;
  logic [31:0]     perf_issued, perf_taken;
`endif

  int checks   = 0;
  int failures = 0;
  logic carry_m = 1'b0;
  int issued_m = 0;
  int taken_m  = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.SETTLE_CYCLES(SETTLE), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_pc(cmd_pc), .cmd_off(cmd_off),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_b_inv(alu_b_inv),
    .alu_cin(alu_cin), .alu_br_type(alu_br_type),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_will_branch(alu_will_branch),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_wb(rsp_wb), .rsp_br_taken(rsp_br_taken), .rsp_br_target(rsp_br_target),
    .rsp_err(rsp_err),
`ifdef SEQ_PERF_CNT_EN
    .perf_clr(perf_clr), .perf_issued(perf_issued), .perf_taken(perf_taken),
`endif
    .carry_flag(carry_flag)
  );

  // Combinational ALU the sequencer drives
  logic [31:0] bb;
  logic [32:0] sum;
  always_comb begin
    bb  = alu_b_inv ? ~alu_b : alu_b;
    sum = {1'b0, alu_a} + {1'b0, bb} + 33'(alu_cin);
    case (alu_op)
      3'b000:  alu_result = alu_a & bb;
      3'b001:  alu_result = alu_a ^ bb;
      3'b010:  alu_result = sum[31:0];
      3'b101:  alu_result = alu_a << bb[4:0];
      3'b110:  alu_result = alu_a >> bb[4:0];
      3'b111:  alu_result = 32'($signed(alu_a) >>> bb[4:0]);
      default: alu_result = 32'd0;
    endcase
    alu_cout = sum[32];
    case (alu_br_type)
      2'b00:   alu_will_branch = (sum[31:0] == 32'd0);
      2'b01:   alu_will_branch = (sum[31:0] != 32'd0);
      2'b10:   alu_will_branch = sum[31];
      default: alu_will_branch = 1'b0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Architectural meaning of each command
  function automatic void ref_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, output logic [31:0] d, output logic wb,
                                  output logic tk, output logic err, output logic cout);
    logic [32:0] w;
    d = 32'd0; wb = 1'b1; tk = 1'b0; err = 1'b0; cout = cin;
    case (op)
      4'd0:  begin w = {1'b0, a} + {1'b0, b}; d = w[31:0]; cout = w[32]; end
      4'd1:  begin d = a - b; cout = (a >= b); end
      4'd2:  d = a & b;
      4'd3:  d = a ^ b;
      4'd4:  d = a << b[4:0];
      4'd5:  d = a >> b[4:0];
      4'd6:  d = 32'($signed(a) >>> b[4:0]);
      4'd7:  begin d = 32'd0 - b; cout = (b == 32'd0); end
      4'd8:  begin w = {1'b0, a} + {1'b0, b} + 33'(cin); d = w[31:0]; cout = w[32]; end
      4'd9:  begin d = a; wb = 1'b0; tk = (a == 32'd0); end
      4'd10: begin d = a; wb = 1'b0; tk = (a != 32'd0); end
      4'd11: begin d = a; wb = 1'b0; tk = a[31]; end
      default: begin wb = 1'b0; err = 1'b1; end
    endcase
  endfunction

  // Issue one command, hold rsp_ready low for 'hold' cycles, check and retire
  task automatic run_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] off, input int hold);
    logic [31:0] ed, et;
    logic ewb, etk, eerr, ec;
    int n;
    ref_cmd(op, a, b, carry_m, ed, ewb, etk, eerr, ec);
    et = eerr ? 32'd0 : pc + off;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_pc = pc; cmd_off = off;
    rsp_ready = (hold == 0);
    @(posedge clk);
    issued_m++;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
    chk("latency", 64'(n), eerr ? 64'(1) : 64'(SETTLE + 2));
    if (!rsp_valid) return;
    carry_m = ec;
    for (int i = 0; i <= hold; i++) begin
      chk("rsp_valid", 64'(rsp_valid), 64'(1));
      chk("rsp_data", 64'(rsp_data), 64'(ed));
      chk("rsp_wb", 64'(rsp_wb), 64'(ewb));
      chk("rsp_br_taken", 64'(rsp_br_taken), 64'(etk));
      chk("rsp_err", 64'(rsp_err), 64'(eerr));
      chk("rsp_br_target", 64'(rsp_br_target), 64'(et));
      chk("carry_flag", 64'(carry_flag), 64'(carry_m));
      chk("cmd_ready_busy", 64'(cmd_ready), 64'(0));
      if (i < hold) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    if (etk) taken_m++;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 64'(rsp_valid), 64'(0));
    chk("cmd_ready_after", 64'(cmd_ready), 64'(1));
    chk("br_type_idle", 64'(alu_br_type), 64'(2'b11));
  endtask

  initial begin
    logic [3:0] rop;
    logic [31:0] ra, rb;
    int n;
    logic saw;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    cmd_pc = '0; cmd_off = '0; rsp_ready = 1'b0;
`ifdef SEQ_PERF_CNT_EN
    perf_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_data", 64'(rsp_data), 64'(0));
    chk("rst_alu_br_type", 64'(alu_br_type), 64'(2'b11));
    chk("rst_alu_op", 64'(alu_op), 64'(0));
    chk("rst_carry", 64'(carry_flag), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("first_rsp_err", 64'(rsp_err), 64'(0));

    run_cmd(4'd0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 0);
    chk("add_carry_set", 64'(carry_flag), 64'(1));
    run_cmd(4'd8, 32'd0, 32'd0, 32'h0, 32'h0, 1);
    run_cmd(4'd1, 32'd5, 32'd7, 32'h0, 32'h0, 0);
    run_cmd(4'd7, 32'd0, 32'd3, 32'h0, 32'h0, 2);
    run_cmd(4'd9, 32'd0, 32'd0, 32'h100, 32'h20, 0);
    run_cmd(4'd11, 32'd1, 32'd0, 32'h100, 32'h20, 0);
    run_cmd(4'd6, 32'h8000_0000, 32'd4, 32'h0, 32'h0, 5);
    run_cmd(4'd13, 32'd1, 32'd2, 32'h0, 32'h0, 0);

    // Make carry 1, then reset during SETTLE of an ADD
    run_cmd(4'd0, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'h0, 0);
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 32'hFFFF_FFFF; cmd_b = 32'd1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_carry", 64'(carry_flag), 64'(0));
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    carry_m = 1'b0; issued_m = 0; taken_m = 0;
    saw = 1'b0;
    repeat (8) begin @(negedge clk); if (rsp_valid) saw = 1'b1; end
    chk("midrst_no_rsp", 64'(saw), 64'(0));

    run_cmd(4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h40, 32'h4, 0);
    run_cmd(4'd10, 32'd9, 32'd0, 32'h200, 32'hFFFF_FFF0, 1);
    run_cmd(4'd3, 32'hAAAA_5555, 32'h1234_5678, 32'h0, 32'h8, 0);
`ifdef SEQ_PERF_CNT_EN
    chk("perf_issued3", 64'(perf_issued), 64'(3));
    chk("perf_taken1", 64'(perf_taken), 64'(1));
`endif

    for (int k = 0; k < 60; k++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'hFFFF_FFFF - ra + 32'($urandom_range(0, 1));
      run_cmd(rop, ra, rb, $urandom, $urandom, $urandom_range(0, 3));
    end

`ifdef SEQ_PERF_CNT_EN
    chk("perf_issued", 64'(perf_issued), 64'(issued_m));
    chk("perf_taken", 64'(perf_taken), 64'(taken_m));
    perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0;
    chk("perf_clr_issued", 64'(perf_issued), 64'(0));
    chk("perf_clr_taken", 64'(perf_taken), 64'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
